// File: rtl/servo_pwm_pkg.sv
// Shared types and default constants for the multi-channel servo PWM block.
package servo_pwm_pkg;

  localparam int SERVO_CNT_W      = 32;
  localparam int SERVO_DEF_PERIOD = 1000000;
  localparam int SERVO_MIN_ON_DEF = 50000;
  localparam int SERVO_MAX_ON_DEF = 100000;
  localparam int SERVO_MAX_CH     = 32;

  typedef logic [SERVO_CNT_W-1:0]          cnt_t;
  typedef logic [$clog2(SERVO_MAX_CH)-1:0] ch_idx_t;

endpackage

// File: rtl/servo_pwm_multi_channel.sv
// One PWM channel: on-time shadow, frame-latched active on-time and the
// registered compare. Optional clamp of the loaded on-time is enabled by
// defining SERVO_PWM_CLAMP_EN.
module pwm_channel
  import servo_pwm_pkg::*;
#(
  parameter int CNT_W  = SERVO_CNT_W,
  parameter int MIN_ON = SERVO_MIN_ON_DEF,
  parameter int MAX_ON = SERVO_MAX_ON_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] p_act,
  input  logic             boundary,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_val,
  input  logic             en,
  output logic             pwm
);

  logic [CNT_W-1:0] on_sh_reg;
  logic [CNT_W-1:0] on_act_reg;
  logic [CNT_W-1:0] on_load;

`ifdef SERVO_PWM_CLAMP_EN
  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_ON);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_ON);
  logic [CNT_W-1:0] on_lo;

  // Clamp the shadow value on its way into the active register: floor first, then ceiling.
  always_comb begin
    on_lo   = (on_sh_reg < MIN_C) ? MIN_C : on_sh_reg;
    on_load = (on_lo > MAX_C) ? MAX_C : on_lo;
  end
`else
  logic unused_clamp;
  assign unused_clamp = ^{MIN_ON, MAX_ON};
  assign on_load      = on_sh_reg;
`endif

  // Shadow write, frame-boundary load and registered compare; a zero period forces the output low.
  always_ff @(posedge clk) begin
    if (rst) begin
      on_sh_reg  <= '0;
      on_act_reg <= '0;
      pwm        <= 1'b0;
    end else begin
      if (wr_en)    on_sh_reg  <= wr_val;
      if (boundary) on_act_reg <= on_load;
      pwm <= en && (p_act != '0) && (cnt < on_act_reg);
    end
  end

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM generator: shared frame counter, period shadow,
// enable latch and frame_start pulse; per-channel logic lives in pwm_channel.
// Optional feature macro: SERVO_PWM_CLAMP_EN (clamps loaded on-times to MIN_ON..MAX_ON).
module servo_pwm_multi
  import servo_pwm_pkg::*;
#(
  parameter int CH_COUNT       = 4,
  parameter int CNT_W          = SERVO_CNT_W,
  parameter int DEFAULT_PERIOD = SERVO_DEF_PERIOD,
  parameter int MIN_ON         = SERVO_MIN_ON_DEF,
  parameter int MAX_ON         = SERVO_MAX_ON_DEF,
  localparam int CH_W          = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [CNT_W-1:0]    cfg_on,
  input  logic                per_we,
  input  logic [CNT_W-1:0]    per_val,
  input  logic [CH_COUNT-1:0] ch_en,
  output logic [CH_COUNT-1:0] pwm,
  output logic                frame_start
);

  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEFAULT_PERIOD);

  logic [CNT_W-1:0]    cnt_reg;
  logic [CNT_W-1:0]    p_act_reg;
  logic [CNT_W-1:0]    p_sh_reg;
  logic [CH_COUNT-1:0] en_act_reg;
  logic                boundary;

  // Last cycle of a frame; a zero period makes every cycle a boundary with cnt parked at 0.
  assign boundary = (p_act_reg == '0) || (cnt_reg == p_act_reg - CNT_W'(1));

  // Frame counter, period shadow/active pair, enable latch and frame_start pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg     <= '0;
      p_act_reg   <= DEF_P;
      p_sh_reg    <= DEF_P;
      en_act_reg  <= '0;
      frame_start <= 1'b0;
    end else begin
      if (per_we) p_sh_reg <= per_val;
      frame_start <= boundary;
      if (boundary) begin
        cnt_reg    <= '0;
        p_act_reg  <= p_sh_reg;
        en_act_reg <= ch_en;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  // One channel per output; out-of-range cfg_ch values match no channel and are dropped.
  for (genvar gi = 0; gi < CH_COUNT; gi++) begin : g_ch
    pwm_channel #(
      .CNT_W  (CNT_W),
      .MIN_ON (MIN_ON),
      .MAX_ON (MAX_ON)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .cnt      (cnt_reg),
      .p_act    (p_act_reg),
      .boundary (boundary),
      .wr_en    (cfg_we && (cfg_ch == CH_W'(gi))),
      .wr_val   (cfg_on),
      .en       (en_act_reg[gi]),
      .pwm      (pwm[gi])
    );
  end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Self-checking bench for servo_pwm_multi: directed scenarios plus random traffic,
// every cycle compared against a frame-position reference model.
module tb_servo_pwm_multi;

  localparam int CH   = 4;
  localparam int W    = 16;
  localparam int DEFP = 20;
  localparam int MINO = 2;
  localparam int MAXO = 6;

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic          cfg_we  = 1'b0;
  logic [1:0]    cfg_ch  = '0;
  logic [W-1:0]  cfg_on  = '0;
  logic          per_we  = 1'b0;
  logic [W-1:0]  per_val = '0;
  logic [CH-1:0] ch_en   = '0;
  logic [CH-1:0] pwm;
  logic          frame_start;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: position within the frame plus latched/pending settings.
  int            m_pos  = 0;
  int            m_p    = DEFP;
  int            m_psh  = DEFP;
  int            m_on   [CH];
  int            m_onsh [CH];
  logic [CH-1:0] m_en   = '0;
  logic [CH-1:0] e_pwm  = '0;
  logic          e_fs   = 1'b0;

  int len;
  int hi [CH];

  always #5 clk = ~clk;

  servo_pwm_multi #(
    .CH_COUNT       (CH),
    .CNT_W          (W),
    .DEFAULT_PERIOD (DEFP),
    .MIN_ON         (MINO),
    .MAX_ON         (MAXO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_on      (cfg_on),
    .per_we      (per_we),
    .per_val     (per_val),
    .ch_en       (ch_en),
    .pwm         (pwm),
    .frame_start (frame_start)
  );

  function automatic int eff_on(int v);
`ifdef SERVO_PWM_CLAMP_EN
    int lo;
    lo = (v < MINO) ? MINO : v;
    return (lo > MAXO) ? MAXO : lo;
`else
    return v;
`endif
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock: predict outputs from the model, then compare after the edge.
  task automatic step();
    logic bnd;
    if (rst) begin
      m_pos = 0; m_p = DEFP; m_psh = DEFP; m_en = '0;
      for (int i = 0; i < CH; i++) begin m_on[i] = 0; m_onsh[i] = 0; end
      e_pwm = '0; e_fs = 1'b0;
    end else begin
      bnd = (m_p == 0) || (m_pos == m_p - 1);
      for (int i = 0; i < CH; i++)
        e_pwm[i] = m_en[i] && (m_p != 0) && (m_pos < m_on[i]);
      e_fs = bnd;
      if (bnd) begin
        m_p = m_psh;
        for (int i = 0; i < CH; i++) m_on[i] = eff_on(m_onsh[i]);
        m_en  = ch_en;
        m_pos = 0;
      end else begin
        m_pos++;
      end
      if (cfg_we) m_onsh[int'(cfg_ch)] = int'(cfg_on);
      if (per_we) m_psh = int'(per_val);
    end
    @(posedge clk);
    #1;
    chk("pwm_model", 32'(pwm), 32'(e_pwm));
    chk("frame_start_model", 32'(frame_start), 32'(e_fs));
  endtask

  task automatic wr_on(int ch, int v);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_on = W'(v);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic wr_per(int v);
    per_we = 1'b1; per_val = W'(v);
    step();
    per_we = 1'b0;
  endtask

  // Step until a frame_start is observed (the stepped cycle was a boundary).
  task automatic sync();
    logic got;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      step();
      if (frame_start) got = 1'b1;
    end
    chk("sync_seen", 32'(got), 32'd1);
  endtask

  // Measure one frame starting at cnt==0: length and high cycles per channel.
  // Optionally write the period shadow at step index wr_at.
  task automatic measure_frame(input int wr_at, input int wr_val,
                               output int flen, output int fhi [CH]);
    logic got;
    got  = 1'b0;
    flen = 0;
    for (int i = 0; i < CH; i++) fhi[i] = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      if (k == wr_at) begin per_we = 1'b1; per_val = W'(wr_val); end
      step();
      per_we = 1'b0;
      flen++;
      for (int i = 0; i < CH; i++) fhi[i] += int'(pwm[i]);
      if (frame_start) got = 1'b1;
    end
    chk("frame_seen", 32'(got), 32'd1);
  endtask

  initial begin
    // Reset state
    for (int i = 0; i < CH; i++) begin m_on[i] = 0; m_onsh[i] = 0; hi[i] = 0; end
    rst = 1'b1;
    step(); step();
    chk("reset_pwm", 32'(pwm), 32'd0);
    chk("reset_fs", 32'(frame_start), 32'd0);
    rst = 1'b0;
    $display("step reset done");

    // 1: basic duty
    wr_per(10);
    wr_on(0, 3);
    ch_en = 4'b0001;
    sync();
    for (int f = 0; f < 2; f++) begin
      measure_frame(-1, 0, len, hi);
      chk("s1_len", 32'(len), 32'd10);
      chk("s1_ch0_high", 32'(hi[0]), 32'd3);
      chk("s1_ch1_high", 32'(hi[1]), 32'd0);
      chk("s1_ch3_high", 32'(hi[3]), 32'd0);
      $display("frame s1.%0d len=%0d ch0_high=%0d", f, len, hi[0]);
    end

    // 2: write exactly in the boundary cycle (cnt==9 of a P=10 frame)
    ch_en = 4'b0011;
    repeat (9) step();
    wr_on(1, 7);
    chk("s2_boundary_fs", 32'(frame_start), 32'd1);
    measure_frame(-1, 0, len, hi);
    chk("s2_old_ch1_high", 32'(hi[1]), 32'd0);
    chk("s2_ch0_high", 32'(hi[0]), 32'd3);
    measure_frame(-1, 0, len, hi);
    chk("s2_new_ch1_high", 32'(hi[1]), 32'd7);
    $display("frame s2 ch1_high=%0d", hi[1]);

    // 3: extremes
    wr_on(0, 0);
    wr_on(1, 10);
    wr_on(2, 15);
    ch_en = 4'b0111;
    sync();
    measure_frame(-1, 0, len, hi);
    chk("s3_on0_high", 32'(hi[0]), 32'd0);
    chk("s3_on10_high", 32'(hi[1]), 32'd10);
    chk("s3_on15_high", 32'(hi[2]), 32'd10);
    $display("frame s3 highs=%0d/%0d/%0d", hi[0], hi[1], hi[2]);
    wr_per(0);
    sync();
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      chk("s3_p0_pwm", 32'(pwm), 32'd0);
      chk("s3_p0_fs", 32'(frame_start), 32'd1);
    end
    $display("step s3 zero-period checked");
    wr_per(10);

    // 4: period change mid-frame
    wr_on(0, 5);
    ch_en = 4'b0001;
    sync(); sync();
    measure_frame(3, 20, len, hi);
    chk("s4_len_old", 32'(len), 32'd10);
    chk("s4_high_old", 32'(hi[0]), 32'd5);
    measure_frame(-1, 0, len, hi);
    chk("s4_len_new", 32'(len), 32'd20);
    chk("s4_high_new", 32'(hi[0]), 32'd5);
    $display("frame s4 len=%0d ch0_high=%0d", len, hi[0]);
    wr_per(10);
    sync(); sync();

    // 5: reset mid-frame with pending writes
    repeat (4) step();
    rst = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_on = W'(9);
    per_we = 1'b1; per_val = W'(30);
    step();
    chk("s5_rst_pwm", 32'(pwm), 32'd0);
    chk("s5_rst_fs", 32'(frame_start), 32'd0);
    rst = 1'b0; cfg_we = 1'b0; per_we = 1'b0;
    ch_en = 4'b1111;
    measure_frame(-1, 0, len, hi);
    chk("s5_first_len", 32'(len), 32'(DEFP));
    chk("s5_first_high", 32'(hi[0]), 32'd0);
    measure_frame(-1, 0, len, hi);
    chk("s5_second_len", 32'(len), 32'(DEFP));
    chk("s5_write_lost", 32'(hi[0]), 32'd0);
    $display("frame s5 len=%0d ch0_high=%0d", len, hi[0]);

    // 6: clamp (expectations follow the build option)
    wr_per(10);
    wr_on(0, 1);
    wr_on(1, 9);
    wr_on(2, 4);
    ch_en = 4'b0111;
    sync(); sync();
    measure_frame(-1, 0, len, hi);
`ifdef SERVO_PWM_CLAMP_EN
    chk("s6_on1", 32'(hi[0]), 32'd2);
    chk("s6_on9", 32'(hi[1]), 32'd6);
`else
    chk("s6_on1", 32'(hi[0]), 32'd1);
    chk("s6_on9", 32'(hi[1]), 32'd9);
`endif
    chk("s6_on4", 32'(hi[2]), 32'd4);
    $display("frame s6 highs=%0d/%0d/%0d", hi[0], hi[1], hi[2]);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      rst     = ($urandom_range(63) == 0);
      cfg_we  = $urandom_range(1);
      cfg_ch  = 2'($urandom_range(3));
      cfg_on  = W'($urandom_range(25));
      per_we  = ($urandom_range(15) == 0);
      per_val = W'($urandom_range(24));
      ch_en   = CH'($urandom);
      step();
    end
    rst = 1'b0; cfg_we = 1'b0; per_we = 1'b0;
    $display("step random phase done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
